// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM:
// opcodes, states, instruction classes and datapath select codes.
package multicycle_control_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ANDI = 6'd12;
    localparam logic [5:0] OP_JM   = 6'd16;
    localparam logic [5:0] OP_BALZ = 6'd26;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_BGEZ = 6'd39;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [1:0] RD_RT   = 2'b00;
    localparam logic [1:0] RD_RD   = 2'b01;
    localparam logic [1:0] RD_LINK = 2'b10;

    localparam logic [1:0] ASB_B    = 2'b00;
    localparam logic [1:0] ASB_FOUR = 2'b01;
    localparam logic [1:0] ASB_IMM  = 2'b10;
    localparam logic [1:0] ASB_BR   = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    localparam logic [2:0] BNJ_SEQ  = 3'b000;
    localparam logic [2:0] BNJ_BEQ  = 3'b001;
    localparam logic [2:0] BNJ_BGEZ = 3'b010;
    localparam logic [2:0] BNJ_BALZ = 3'b011;
    localparam logic [2:0] BNJ_J    = 3'b100;
    localparam logic [2:0] BNJ_JM   = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM    = 4'd3,
        S_WB     = 4'd4,
        S_BRANCH = 4'd5,
        S_JUMP   = 4'd6,
        S_TRAP   = 4'd7
    } state_t;

    typedef struct packed {
        logic r;
        logic j;
        logic beq;
        logic andi;
        logic jm;
        logic balz;
        logic lw;
        logic bgez;
        logic sw;
        logic ill;
    } cls_t;

endpackage

// File: rtl/multicycle_control_opdec.sv
// Opcode to one-hot instruction class; exactly one field
// of the class bundle is set for any opcode value.
module mc_opcode_decode
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] op_i,
    output cls_t                cls_o
);

    always_comb begin
        cls_o = '0;
        unique case (op_i)
            OPCODE_W'(OP_R):    cls_o.r    = 1'b1;
            OPCODE_W'(OP_J):    cls_o.j    = 1'b1;
            OPCODE_W'(OP_BEQ):  cls_o.beq  = 1'b1;
            OPCODE_W'(OP_ANDI): cls_o.andi = 1'b1;
            OPCODE_W'(OP_JM):   cls_o.jm   = 1'b1;
            OPCODE_W'(OP_BALZ): cls_o.balz = 1'b1;
            OPCODE_W'(OP_LW):   cls_o.lw   = 1'b1;
            OPCODE_W'(OP_BGEZ): cls_o.bgez = 1'b1;
            OPCODE_W'(OP_SW):   cls_o.sw   = 1'b1;
            default:            cls_o.ill  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-wait watchdog.
// CTRL_ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W  = 6,
    parameter int STATE_W   = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                stall,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                memread,
    output logic                memwrite,
    output logic                regwrite,
    output logic                memtoreg,
    output logic                alusrc_a,
    output logic [1:0]          regdest,
    output logic [1:0]          alusrc_b,
    output logic [1:0]          aluop,
    output logic [2:0]          bnj,
    output logic                instr_done,
    output logic                mem_timeout,
    output logic                trap
);

    localparam int SB = $bits(state_t);

    logic [STATE_W-1:0]   state_q;
    state_t               st;
    state_t               state_d;
    logic [OPCODE_W-1:0]  op_q, op_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 tmo_q, tmo_d;
    logic [OPCODE_W-1:0]  dec_op;
    logic                 waiting;
    cls_t                 cls;

    assign st = state_t'(state_q[SB-1:0]);

    // Live opcode only matters while choosing the DECODE exit
    assign dec_op = (st == S_DECODE) ? opcode : op_q;

    mc_opcode_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_dec (
        .op_i  (dec_op),
        .cls_o (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            op_q    <= '0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= STATE_W'(state_d);
            op_q    <= op_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
        end
    end

    assign waiting = (st == S_FETCH || st == S_MEM) && !mem_ready;

    always_comb begin
        wd_d  = '0;
        tmo_d = tmo_q;
        if (stall) begin
            wd_d = wd_q;
        end else if (waiting) begin
            wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
            if (wd_q == '1) tmo_d = 1'b1;
        end
    end

    assign mem_timeout = tmo_q;

    always_comb begin
        state_d       = st;
        op_d          = op_q;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        memread       = 1'b0;
        memwrite      = 1'b0;
        regwrite      = 1'b0;
        memtoreg      = 1'b0;
        alusrc_a      = 1'b0;
        regdest       = RD_RT;
        alusrc_b      = ASB_B;
        aluop         = ALU_ADD;
        bnj           = BNJ_SEQ;
        instr_done    = 1'b0;
        trap          = 1'b0;

        unique case (st)
            S_FETCH: begin
                memread  = 1'b1;
                alusrc_b = ASB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d     = opcode;
                alusrc_b = ASB_BR;
                unique case (1'b1)
                    cls.r, cls.andi, cls.lw,
                    cls.sw, cls.jm:
                        state_d = S_EXEC;
                    cls.beq, cls.bgez, cls.balz:
                        state_d = S_BRANCH;
                    cls.j:
                        state_d = S_JUMP;
                    cls.ill: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
`endif
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_EXEC: begin
                alusrc_a = 1'b1;
                if (cls.r) begin
                    aluop   = ALU_FN;
                    state_d = S_WB;
                end else if (cls.andi) begin
                    aluop    = ALU_AND;
                    alusrc_b = ASB_IMM;
                    state_d  = S_WB;
                end else begin
                    alusrc_b = ASB_IMM;
                    state_d  = S_MEM;
                end
            end
            S_MEM: begin
                iord     = 1'b1;
                memwrite = cls.sw;
                memread  = !cls.sw;
                if (mem_ready) begin
                    if (cls.sw) begin
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
                    end else if (cls.jm) begin
                        state_d = S_JUMP;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regwrite   = 1'b1;
                memtoreg   = cls.lw;
                instr_done = 1'b1;
                state_d    = S_FETCH;
                if (cls.r)         regdest = RD_RD;
                else if (cls.balz) regdest = RD_LINK;
            end
            S_BRANCH: begin
                pc_write_cond = 1'b1;
                alusrc_a      = 1'b1;
                aluop         = ALU_SUB;
                unique case (1'b1)
                    cls.beq:  bnj = BNJ_BEQ;
                    cls.bgez: bnj = BNJ_BGEZ;
                    cls.balz: bnj = BNJ_BALZ;
                    default:  bnj = BNJ_SEQ;
                endcase
                if (cls.balz) begin
                    state_d = S_WB;
                end else begin
                    state_d    = S_FETCH;
                    instr_done = 1'b1;
                end
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                bnj        = cls.jm ? BNJ_JM : BNJ_J;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                trap = 1'b1;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase

        // Stall wins over mem_ready: the access simply repeats
        if (stall) begin
            state_d       = st;
            op_d          = op_q;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            regwrite      = 1'b0;
            memwrite      = 1'b0;
            instr_done    = 1'b0;
        end

        if (!rst_n) begin
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            memread       = 1'b0;
            memwrite      = 1'b0;
            regwrite      = 1'b0;
            memtoreg      = 1'b0;
            alusrc_a      = 1'b0;
            regdest       = 2'b00;
            alusrc_b      = 2'b00;
            aluop         = 2'b00;
            bnj           = 3'b000;
            instr_done    = 1'b0;
            trap          = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected
// control words queued by stimulus, checked by a monitor.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       stall = 1'b0;
    logic       ir_write, pc_write, pc_write_cond, iord;
    logic       memread, memwrite, regwrite, memtoreg;
    logic       alusrc_a, instr_done, mem_timeout, trap;
    logic [1:0] regdest, alusrc_b, aluop;
    logic [2:0] bnj;

    typedef struct packed {
        logic       irw, pcw, pcc, iord, mr, mw, rw, m2r, asa;
        logic [1:0] rd, asb, aop;
        logic [2:0] bnj;
        logic       done, tmo, trap;
    } ov_t;

    typedef struct {
        string nm;
        ov_t   e;
    } exp_t;

    exp_t sq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_tmo = 1'b0;
    ov_t  act;

    multicycle_control #(
        .OPCODE_W  (6),
        .STATE_W   (4),
        .TIMEOUT_W (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .stall         (stall),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .memread       (memread),
        .memwrite      (memwrite),
        .regwrite      (regwrite),
        .memtoreg      (memtoreg),
        .alusrc_a      (alusrc_a),
        .regdest       (regdest),
        .alusrc_b      (alusrc_b),
        .aluop         (aluop),
        .bnj           (bnj),
        .instr_done    (instr_done),
        .mem_timeout   (mem_timeout),
        .trap          (trap)
    );

    always #5 clk = ~clk;

    assign act = {ir_write, pc_write, pc_write_cond, iord,
                  memread, memwrite, regwrite, memtoreg,
                  alusrc_a, regdest, alusrc_b, aluop, bnj,
                  instr_done, mem_timeout, trap};

    always @(negedge clk) begin
        exp_t x;
        if (sq.size() > 0) begin
            x = sq.pop_front();
            n_tests++;
            if (act !== x.e) begin
                n_fail++;
                $display("FAIL %s: got %b want %b",
                         x.nm, act, x.e);
            end
        end
    end

    function automatic ov_t f_fetch(bit rdy);
        ov_t o = '0;
        o.mr  = 1'b1;
        o.asb = 2'b01;
        o.irw = rdy;
        o.pcw = rdy;
        return o;
    endfunction

    function automatic ov_t f_decode(bit done);
        ov_t o = '0;
        o.asb  = 2'b11;
        o.done = done;
        return o;
    endfunction

    function automatic ov_t f_exec_r();
        ov_t o = '0;
        o.asa = 1'b1;
        o.aop = 2'b10;
        return o;
    endfunction

    function automatic ov_t f_exec_andi();
        ov_t o = '0;
        o.asa = 1'b1;
        o.asb = 2'b10;
        o.aop = 2'b11;
        return o;
    endfunction

    function automatic ov_t f_exec_mem();
        ov_t o = '0;
        o.asa = 1'b1;
        o.asb = 2'b10;
        return o;
    endfunction

    function automatic ov_t f_mem(bit wr, bit done);
        ov_t o = '0;
        o.iord = 1'b1;
        o.mw   = wr;
        o.mr   = !wr;
        o.done = done;
        return o;
    endfunction

    function automatic ov_t f_wb(logic [1:0] rd, bit m2r);
        ov_t o = '0;
        o.rw   = 1'b1;
        o.rd   = rd;
        o.m2r  = m2r;
        o.done = 1'b1;
        return o;
    endfunction

    function automatic ov_t f_br(logic [2:0] b, bit done);
        ov_t o = '0;
        o.pcc  = 1'b1;
        o.asa  = 1'b1;
        o.aop  = 2'b01;
        o.bnj  = b;
        o.done = done;
        return o;
    endfunction

    function automatic ov_t f_jump(logic [2:0] b);
        ov_t o = '0;
        o.pcw  = 1'b1;
        o.bnj  = b;
        o.done = 1'b1;
        return o;
    endfunction

    function automatic ov_t f_stall(ov_t i);
        ov_t o = i;
        o.irw  = 1'b0;
        o.pcw  = 1'b0;
        o.pcc  = 1'b0;
        o.rw   = 1'b0;
        o.mw   = 1'b0;
        o.done = 1'b0;
        return o;
    endfunction

    task automatic cyc(input bit rdy, input bit st,
                       input ov_t e, input string nm);
        exp_t x;
        mem_ready = rdy;
        stall     = st;
        if (!rst_n) e = '0;
        else        e.tmo = exp_tmo;
        x.nm = nm;
        x.e  = e;
        sq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: sim did not end");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cyc(1, 0, '0, "reset_hold");
        rst_n = 1'b1;

        // lw aborted by reset in MEM
        opcode = 6'd35;
        cyc(1, 0, f_fetch(1), "lwa_fetch");
        cyc(0, 0, f_decode(0), "lwa_dec");
        cyc(0, 0, f_exec_mem(), "lwa_exec");
        cyc(0, 0, f_mem(0, 0), "lwa_mem");
        rst_n = 1'b0;
        cyc(1, 0, '0, "rst_mid_mem");
        cyc(0, 0, '0, "rst_hold");
        rst_n = 1'b1;

        // lw with both accesses 2 cycles late: 9 cycles
        cyc(0, 0, f_fetch(0), "lw_f0");
        cyc(0, 0, f_fetch(0), "lw_f1");
        cyc(1, 0, f_fetch(1), "lw_f2");
        cyc(0, 0, f_decode(0), "lw_dec");
        cyc(0, 0, f_exec_mem(), "lw_exec");
        cyc(0, 0, f_mem(0, 0), "lw_m0");
        cyc(0, 0, f_mem(0, 0), "lw_m1");
        cyc(1, 0, f_mem(0, 0), "lw_m2");
        cyc(0, 0, f_wb(2'b00, 1), "lw_wb");

        // R-type; opcode bus changes after DECODE
        opcode = 6'd0;
        cyc(1, 0, f_fetch(1), "r_fetch");
        cyc(0, 0, f_decode(0), "r_dec");
        opcode = 6'd63;
        cyc(0, 0, f_exec_r(), "r_exec");
        cyc(0, 0, f_wb(2'b01, 0), "r_wb");

        opcode = 6'd43;
        cyc(1, 0, f_fetch(1), "sw_fetch");
        cyc(1, 0, f_decode(0), "sw_dec");
        cyc(1, 0, f_exec_mem(), "sw_exec");
        cyc(1, 0, f_mem(1, 1), "sw_mem");

        opcode = 6'd26;
        cyc(1, 0, f_fetch(1), "balz_fetch");
        cyc(0, 0, f_decode(0), "balz_dec");
        cyc(0, 0, f_br(3'b011, 0), "balz_br");
        cyc(0, 0, f_wb(2'b10, 0), "balz_wb");

        opcode = 6'd4;
        cyc(1, 0, f_fetch(1), "beq_fetch");
        cyc(0, 0, f_decode(0), "beq_dec");
        cyc(0, 0, f_br(3'b001, 1), "beq_br");

        opcode = 6'd39;
        cyc(1, 0, f_fetch(1), "bgez_fetch");
        cyc(0, 0, f_decode(0), "bgez_dec");
        cyc(0, 0, f_br(3'b010, 1), "bgez_br");

        opcode = 6'd16;
        cyc(1, 0, f_fetch(1), "jm_fetch");
        cyc(0, 0, f_decode(0), "jm_dec");
        cyc(0, 0, f_exec_mem(), "jm_exec");
        cyc(0, 0, f_mem(0, 0), "jm_m0");
        cyc(1, 0, f_mem(0, 0), "jm_m1");
        cyc(0, 0, f_jump(3'b101), "jm_jump");

        opcode = 6'd2;
        cyc(1, 0, f_fetch(1), "j_fetch");
        cyc(0, 0, f_decode(0), "j_dec");
        cyc(0, 0, f_jump(3'b100), "j_jump");

        // andi with stalls in FETCH, EXEC and WB
        opcode = 6'd12;
        cyc(1, 1, f_stall(f_fetch(1)), "andi_stf0");
        cyc(1, 1, f_stall(f_fetch(1)), "andi_stf1");
        cyc(1, 0, f_fetch(1), "andi_fetch");
        cyc(0, 0, f_decode(0), "andi_dec");
        for (int i = 0; i < 3; i++)
            cyc(1, 1, f_stall(f_exec_andi()), "andi_ste");
        cyc(0, 0, f_exec_andi(), "andi_exec");
        cyc(0, 1, f_stall(f_wb(2'b00, 0)), "andi_stwb");
        cyc(0, 0, f_wb(2'b00, 0), "andi_wb");

        // watchdog: 256th wait cycle saturates
        opcode = 6'd2;
        for (int i = 0; i < 256; i++)
            cyc(0, 0, f_fetch(0), "wd_wait");
        exp_tmo = 1'b1;
        cyc(0, 0, f_fetch(0), "wd_sticky");
        cyc(1, 0, f_fetch(1), "wd_fetch");
        cyc(0, 0, f_decode(0), "wd_dec");
        cyc(0, 0, f_jump(3'b100), "wd_jump");

        // illegal opcode
        opcode = 6'd63;
        cyc(1, 0, f_fetch(1), "ill_fetch");
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc(0, 0, f_decode(0), "ill_dec");
        for (int i = 0; i < 100; i++) begin
            ov_t t;
            t = '0;
            t.trap = 1'b1;
            cyc(i[0], 0, t, "trap_hold");
        end
        rst_n = 1'b0;
        cyc(0, 0, '0, "trap_rst");
        rst_n = 1'b1;
        exp_tmo = 1'b0;
        cyc(0, 0, f_fetch(0), "trap_refetch");
`else
        cyc(0, 0, f_decode(1), "ill_nop");
        opcode = 6'd2;
        cyc(1, 0, f_fetch(1), "ill_next_fetch");
        cyc(0, 0, f_decode(0), "ill_next_dec");
        cyc(0, 0, f_jump(3'b100), "ill_next_jump");
`endif

        n_tests++;
        if (sq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0",
                     sq.size());
        end
        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
